mode_select_fsm: RTL and testbench
==================================

MODE_SELECT_FSM -- requirements
Module: mode_select_fsm

Interface
REQ-001 SHALL use parameter LONG_CYC, default 100_000_000: hold length in clk cycles that counts as a long press (2 s at 50 MHz).
REQ-002 SHALL use parameter TIMEOUT_S, default 30: number of tick_1hz pulses without a press before a setting mode is abandoned.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port btn_level, input, 1: debounced mode-button level; 1 = released, 0 = pressed.
REQ-006 SHALL have port tick_1hz, input, 1: one-clk-wide pulse once per second.
REQ-007 SHALL have port mode, output, 2: current mode; NORMAL=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
REQ-008 SHALL have port setting, output, 1: 1 when mode != NORMAL.
REQ-009 SHALL have port blink, output, 1: blink phase for the digits being edited.
REQ-010 SHALL have port mode_chg, output, 1: one-clk pulse on every change of mode value.

Function
REQ-011 SHALL register btn_prev each cycle; press edge = btn_prev=1 and btn_level=0; release edge = btn_prev=0 and btn_level=1.
REQ-012 SHALL implement press FSM states IDLE, PRESSED and HELD.
REQ-013 IDLE SHALL go to PRESSED on a press edge, with hold_cnt cleared to 0.
REQ-014 PRESSED SHALL increment hold_cnt each cycle while btn_level=0.
REQ-015 PRESSED with a release edge before hold_cnt reaches LONG_CYC-1 SHALL count as a short press: advance mode (NORMAL->SET_HOUR->SET_MIN->SET_SEC->NORMAL, wrap), then go to IDLE.
REQ-016 PRESSED with hold_cnt = LONG_CYC-1 and btn_level=0 SHALL count as a long press: set mode to NORMAL, then go to HELD.
REQ-017 HELD SHALL ignore the button until a release edge, then go to IDLE with no mode change.
REQ-018 The mode register SHALL update on the same clk edge that samples the qualifying release or hold condition, so the new value is visible one cycle after the event.
REQ-019 mode_chg SHALL be asserted for exactly the one cycle in which the new mode value first appears; a long press while already in NORMAL SHALL NOT pulse mode_chg.
REQ-020 The idle_sec counter SHALL increment on tick_1hz only while setting=1 and the FSM is in IDLE.
REQ-021 The idle_sec counter SHALL clear on any press edge and on any mode change.
REQ-022 When idle_sec reaches TIMEOUT_S, mode SHALL go to NORMAL with a mode_chg pulse and idle_sec SHALL clear.
REQ-023 Timeout SHALL NOT fire while in PRESSED or HELD; if a press edge and the final tick_1hz coincide, the press SHALL win and idle_sec SHALL clear.
REQ-024 blink SHALL toggle on each tick_1hz while setting=1, and SHALL be forced to 0 whenever mode=NORMAL; blink SHALL restart at 1 on each mode change into a setting mode.
REQ-025 hold_cnt width SHALL be clog2(LONG_CYC) and hold_cnt SHALL saturate and never wrap.
REQ-026 idle_sec width SHALL be clog2(TIMEOUT_S+1).
REQ-027 setting SHALL be combinational from mode.
REQ-028 All other outputs SHALL be registered.

Reset
REQ-029 On rst=1 at a clk edge: FSM=IDLE, mode=NORMAL, mode_chg=0, blink=0, hold_cnt=0, idle_sec=0, btn_prev=1.
REQ-030 rst SHALL take priority over all events.
REQ-031 A press in progress during reset SHALL be discarded.
REQ-032 A button still held when rst deasserts SHALL register as a new press edge, because btn_prev resets to 1.

Structure
REQ-033 Mode encodings (MODE_NORMAL..MODE_SET_SEC) and FSM state encodings SHALL live in shared package clock_pkg, which the time counters also use.
REQ-034 The block SHALL be a single module with no sub-module; the edge detect SHALL be inline.

Verification (bench LONG_CYC=20, TIMEOUT_S=3)
REQ-035 Press for 5 cycles then release -> mode 0->1 one cycle after the release edge, with mode_chg high for 1 cycle.
REQ-036 Four short presses -> mode sequence 1,2,3,0, with exactly four mode_chg pulses.
REQ-037 In mode 2, hold for 25 cycles -> mode=0 at hold cycle 20; the release then causes no change and no pulse.
REQ-038 In mode 1 with no press, three tick_1hz pulses -> mode=0 and mode_chg pulses after the 3rd tick; blink reads 1,0,1 before the change and 0 after.
REQ-039 Assert rst mid-press at hold cycle 10 with the button kept low -> after reset mode=0; a release at cycle 15 counts as a short press, giving mode=1.
REQ-040 Press edge in the same cycle as the 3rd tick_1hz while in mode 3 -> no timeout and idle_sec=0; the later release gives mode=0 via wrap, with one mode_chg pulse.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared clock-domain encodings: display modes and the mode-button press FSM states.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } press_state_e;

    // Short-press mode sequence, wrapping back to NORMAL after SET_SEC.
    function automatic mode_e next_mode(input mode_e m);
        mode_e r;
        case (m)
            MODE_NORMAL:   r = MODE_SET_HOUR;
            MODE_SET_HOUR: r = MODE_SET_MIN;
            MODE_SET_MIN:  r = MODE_SET_SEC;
            default:       r = MODE_NORMAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mode_select_fsm.sv
// Mode-button handler: short press steps through setting modes, long press returns
// to NORMAL, and inactivity in a setting mode times out back to NORMAL.
module mode_select_fsm
    import clock_pkg::*;
#(
    parameter int unsigned LONG_CYC  = 100_000_000,
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_level,
    input  logic       tick_1hz,
    output logic [1:0] mode,
    output logic       setting,
    output logic       blink,
    output logic       mode_chg
);

    localparam int unsigned HOLD_W = $clog2(LONG_CYC);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);

    press_state_e      state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDLE_W-1:0] idle_sec_q, idle_sec_d;
    logic              btn_prev_q, btn_prev_d;
    logic              blink_q, blink_d;
    logic              mode_chg_q, mode_chg_d;
    logic              press_edge, release_edge;

    assign setting  = (mode_q != MODE_NORMAL);
    assign mode     = mode_q;
    assign blink    = blink_q;
    assign mode_chg = mode_chg_q;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        hold_cnt_d   = hold_cnt_q;
        idle_sec_d   = idle_sec_q;
        blink_d      = blink_q;
        btn_prev_d   = btn_level;
        press_edge   = btn_prev_q & ~btn_level;
        release_edge = ~btn_prev_q & btn_level;

        case (state_q)
            ST_IDLE: begin
                if (press_edge) begin
                    state_d    = ST_PRESSED;
                    hold_cnt_d = '0;
                end
            end
            ST_PRESSED: begin
                if (release_edge) begin
                    mode_d  = next_mode(mode_q);
                    state_d = ST_IDLE;
                end else if (!btn_level) begin
                    // Counter stops at HOLD_LAST since reaching it leaves PRESSED.
                    if (hold_cnt_q == HOLD_LAST) begin
                        mode_d  = MODE_NORMAL;
                        state_d = ST_HELD;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            ST_HELD: begin
                if (release_edge) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inactivity timeout; a press on the same cycle as the final tick wins.
        if (press_edge) begin
            idle_sec_d = '0;
        end else if (setting && (state_q == ST_IDLE) && tick_1hz) begin
            if (idle_sec_q == IDLE_LAST) begin
                mode_d     = MODE_NORMAL;
                idle_sec_d = '0;
            end else begin
                idle_sec_d = idle_sec_q + IDLE_W'(1);
            end
        end

        mode_chg_d = (mode_d != mode_q);
        if (mode_chg_d) begin
            idle_sec_d = '0;
        end

        if (mode_d == MODE_NORMAL) begin
            blink_d = 1'b0;
        end else if (mode_chg_d) begin
            blink_d = 1'b1;
        end else if (tick_1hz && setting) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_NORMAL;
            hold_cnt_q <= '0;
            idle_sec_q <= '0;
            btn_prev_q <= 1'b1;
            blink_q    <= 1'b0;
            mode_chg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            hold_cnt_q <= hold_cnt_d;
            idle_sec_q <= idle_sec_d;
            btn_prev_q <= btn_prev_d;
            blink_q    <= blink_d;
            mode_chg_q <= mode_chg_d;
        end
    end

endmodule

// File: tb/tb_mode_select_fsm.sv
// Directed bench for mode_select_fsm with LONG_CYC=20, TIMEOUT_S=3.
module tb_mode_select_fsm;

    localparam int OP_SHORT = 0;
    localparam int OP_LONG  = 1;
    localparam int OP_TICK  = 2;
    localparam int NVEC     = 17;

    typedef struct {
        int         kind;
        int         n;
        logic [1:0] exp_mode;
        int         exp_chg;
        logic       exp_blink;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_level = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [1:0] mode;
    logic       setting;
    logic       blink;
    logic       mode_chg;

    int n_tests = 0;
    int n_fail  = 0;
    int chg_seen = 0;
    vec_t tbl [NVEC];

    mode_select_fsm #(.LONG_CYC(20), .TIMEOUT_S(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_level (btn_level),
        .tick_1hz  (tick_1hz),
        .mode      (mode),
        .setting   (setting),
        .blink     (blink),
        .mode_chg  (mode_chg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (mode_chg === 1'b1) chg_seen++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_press(input int n);
        btn_level = 1'b0;
        repeat (n) step();
        btn_level = 1'b1;
        step();
        step();
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
        end
    endtask

    initial begin
        tbl[0]  = '{OP_SHORT, 5,  2'd1, 1, 1'b1};
        tbl[1]  = '{OP_SHORT, 3,  2'd2, 1, 1'b1};
        tbl[2]  = '{OP_SHORT, 3,  2'd3, 1, 1'b1};
        tbl[3]  = '{OP_SHORT, 3,  2'd0, 1, 1'b0};
        tbl[4]  = '{OP_LONG,  25, 2'd0, 0, 1'b0};
        tbl[5]  = '{OP_SHORT, 2,  2'd1, 1, 1'b1};
        tbl[6]  = '{OP_TICK,  1,  2'd1, 0, 1'b0};
        tbl[7]  = '{OP_TICK,  1,  2'd1, 0, 1'b1};
        tbl[8]  = '{OP_TICK,  1,  2'd0, 1, 1'b0};
        tbl[9]  = '{OP_TICK,  2,  2'd0, 0, 1'b0};
        tbl[10] = '{OP_SHORT, 19, 2'd1, 1, 1'b1};
        tbl[11] = '{OP_LONG,  25, 2'd0, 1, 1'b0};
        tbl[12] = '{OP_SHORT, 4,  2'd1, 1, 1'b1};
        tbl[13] = '{OP_TICK,  2,  2'd1, 0, 1'b1};
        tbl[14] = '{OP_SHORT, 4,  2'd2, 1, 1'b1};
        tbl[15] = '{OP_TICK,  2,  2'd2, 0, 1'b1};
        tbl[16] = '{OP_TICK,  2,  2'd0, 1, 1'b0};

        // Reset state
        step();
        step();
        check("rst_mode", 32'(mode), 0);
        check("rst_setting", 32'(setting), 0);
        check("rst_blink", 32'(blink), 0);
        check("rst_chg", 32'(mode_chg), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < NVEC; i++) begin
            chg_seen = 0;
            case (tbl[i].kind)
                OP_TICK: do_tick(tbl[i].n);
                default: do_press(tbl[i].n);
            endcase
            check($sformatf("vec%0d_mode", i), 32'(mode), 32'(tbl[i].exp_mode));
            check($sformatf("vec%0d_chg_count", i), 32'(chg_seen), 32'(tbl[i].exp_chg));
            check($sformatf("vec%0d_blink", i), 32'(blink), 32'(tbl[i].exp_blink));
            check($sformatf("vec%0d_setting", i), 32'(setting), 32'(tbl[i].exp_mode != 2'd0));
        end

        // Short press timing: change visible right after the release edge, one-cycle pulse
        btn_level = 1'b0;
        repeat (5) step();
        check("short_before_release", 32'(mode), 0);
        btn_level = 1'b1;
        step();
        check("short_mode", 32'(mode), 1);
        check("short_chg_hi", 32'(mode_chg), 1);
        step();
        check("short_chg_lo", 32'(mode_chg), 0);

        // Long press from SET_MIN: NORMAL appears on the 21st low-sampled edge
        do_press(3);
        check("long_pre_mode", 32'(mode), 2);
        btn_level = 1'b0;
        repeat (20) step();
        check("long_before", 32'(mode), 2);
        step();
        check("long_mode", 32'(mode), 0);
        check("long_chg_hi", 32'(mode_chg), 1);
        repeat (3) step();
        check("long_chg_lo", 32'(mode_chg), 0);
        btn_level = 1'b1;
        step();
        check("long_release_mode", 32'(mode), 0);
        check("long_release_chg", 32'(mode_chg), 0);
        step();

        // Reset mid-press with button held: held button becomes a fresh press
        do_press(3);
        do_press(3);
        check("rstp_pre_mode", 32'(mode), 2);
        btn_level = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        check("rstp_mode", 32'(mode), 0);
        check("rstp_chg", 32'(mode_chg), 0);
        check("rstp_blink", 32'(blink), 0);
        rst = 1'b0;
        repeat (5) step();
        check("rstp_hold_mode", 32'(mode), 0);
        btn_level = 1'b1;
        step();
        check("rstp_release_mode", 32'(mode), 1);
        check("rstp_release_chg", 32'(mode_chg), 1);
        step();

        // Press edge coincides with the final tick in SET_SEC: press wins
        do_press(3);
        do_press(3);
        check("race_pre_mode", 32'(mode), 3);
        do_tick(2);
        check("race_ticks_mode", 32'(mode), 3);
        btn_level = 1'b0;
        tick_1hz  = 1'b1;
        step();
        tick_1hz  = 1'b0;
        check("race_mode", 32'(mode), 3);
        check("race_chg", 32'(mode_chg), 0);
        check("race_idle_sec", 32'(dut.idle_sec_q), 0);
        repeat (3) step();
        check("race_hold_mode", 32'(mode), 3);
        chg_seen = 0;
        btn_level = 1'b1;
        step();
        check("race_release_mode", 32'(mode), 0);
        check("race_release_chg", 32'(mode_chg), 1);
        step();
        step();
        check("race_chg_count", 32'(chg_seen), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
